// File: rtl/configurable_decode_controller_if.sv
// Byte-stream link between the host, the decode controller and the result sink.
// The slave side is the controller: it consumes input bytes and produces result bytes.
interface configurable_decode_controller_if;
  logic [7:0] input_data;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] output_data;
  logic       output_valid;
  logic       output_ready;

  modport slave (
    input  input_data, input_valid, output_ready,
    output input_ready, output_data, output_valid
  );

  modport master (
    output input_data, input_valid, output_ready,
    input  input_ready, output_data, output_valid
  );
endinterface

// File: rtl/configurable_decode_controller.sv
// Stage controller for the decoder PE array: loads syndrome rounds, runs bounded grow/merge
// iterations, then streams a framed result (6-byte header + per-round corrections).
module configurable_decode_controller #(
  parameter int GRID_WIDTH_X            = 4,
  parameter int GRID_WIDTH_Z            = 1,
  parameter int GRID_WIDTH_U            = 3,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAX_ITERATIONS          = 255,
  parameter int MAXIMUM_DELAY           = 2,
  localparam int PU_PER_ROUND    = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int BYTES_PER_ROUND = (PU_PER_ROUND + 7) / 8,
  localparam int ALIGNED         = 8 * BYTES_PER_ROUND,
  localparam int CORR_W          = (GRID_WIDTH_X - 1) * GRID_WIDTH_Z
                                 + ((GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1)
                                 + GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int CORR_BYTES      = (CORR_W + 7) / 8,
  localparam int PU_COUNT        = PU_PER_ROUND * GRID_WIDTH_U,
  localparam int STAGE_WIDTH     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  configurable_decode_controller_if.slave link,
  input  logic [PU_COUNT-1:0]        busy_PE,
  input  logic [PU_COUNT-1:0]        odd_clusters_PE,
  output logic [ALIGNED-1:0]         measurements,
  input  logic [CORR_W-1:0]          correction,
  output logic [STAGE_WIDTH-1:0]     global_stage
);

  localparam logic [2:0] S_IDLE  = 3'd0, S_PARAM = 3'd1, S_PREP = 3'd2, S_LOAD = 3'd3,
                         S_GROW  = 3'd4, S_MERGE = 3'd5, S_PEEL = 3'd6, S_RV   = 3'd7;
  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  localparam int ITW   = ITERATION_COUNTER_WIDTH;
  localparam int RND_W = $clog2(GRID_WIDTH_U + 1);
  localparam int BC_W  = $clog2(BYTES_PER_ROUND + 1);
  localparam int DLY_W = (MAXIMUM_DELAY < 1) ? 1 : $clog2(MAXIMUM_DELAY + 1);
  localparam int OB_W  = $clog2(CORR_BYTES + 1);

  localparam logic [RND_W-1:0] ROUNDS_MAX = RND_W'(GRID_WIDTH_U);
  localparam logic [RND_W-1:0] ONE_R      = RND_W'(1);
  localparam logic [7:0]       U_BYTE     = 8'(GRID_WIDTH_U);
  localparam logic [BC_W-1:0]  BYTE_LAST  = BC_W'(BYTES_PER_ROUND - 1);
  localparam logic [DLY_W-1:0] DLY_MAX    = DLY_W'(MAXIMUM_DELAY);
  localparam logic [ITW-1:0]   ITER_MAX   = ITW'(MAX_ITERATIONS);
  localparam logic [OB_W-1:0]  OB_LAST    = OB_W'(CORR_BYTES - 1);
  localparam logic [2:0]       HDR_BYTES  = 3'd6;

  logic [2:0]        state, state_nx;
  logic              busy_r, odd_r;
  logic [RND_W-1:0]  rounds_cfg, rounds_loaded, wr_cnt, out_round;
  logic [BC_W-1:0]   byte_cnt;
  logic [DLY_W-1:0]  delay_cnt;
  logic [ITW-1:0]    iteration_counter;
  logic [31:0]       cycle_counter, cycle_nx, hdr_cycles;
  logic [1:0]        status, status_nx, hdr_status;
  logic [7:0]        hdr_iter;
  logic [GRID_WIDTH_U-1:0][CORR_W-1:0] corr_buf;
  logic              frame_active;
  logic [2:0]        hdr_idx;
  logic [OB_W-1:0]   out_byte;
  logic [ALIGNED-1:0] meas_shift;
  logic [CORR_BYTES*8-1:0] corr_pad;
  logic              in_fire, out_fire, delay_done, settle, timeout_take, hdr_phase;

  if (ALIGNED > 8) begin : g_meas_wide
    assign meas_shift = {link.input_data, measurements[ALIGNED-1:8]};
  end else begin : g_meas_narrow
    assign meas_shift = link.input_data;
  end

  assign in_fire      = link.input_valid && link.input_ready;
  assign out_fire     = link.output_valid && link.output_ready;
  assign delay_done   = (delay_cnt == DLY_MAX);
  assign settle       = (state == S_MERGE) || (state == S_PEEL);
  assign timeout_take = (state == S_MERGE) && delay_done && !busy_r && odd_r &&
                        (iteration_counter == ITER_MAX);
  assign hdr_phase    = (hdr_idx != HDR_BYTES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_fire) begin
                 if (link.input_data == START_DECODING_MSG)           state_nx = S_PARAM;
                 else if (link.input_data == MEASUREMENT_DATA_HEADER) state_nx = S_PREP;
               end
      S_PARAM: if (in_fire) state_nx = S_IDLE;
      S_PREP:  if (in_fire && byte_cnt == BYTE_LAST) state_nx = S_LOAD;
      S_LOAD:  state_nx = (rounds_loaded < rounds_cfg) ? S_PREP : S_MERGE;
      S_GROW:  state_nx = S_MERGE;
      S_MERGE: if (delay_done && !busy_r) begin
                 if (!odd_r || iteration_counter == ITER_MAX) state_nx = S_PEEL;
                 else                                         state_nx = S_GROW;
               end
      S_PEEL:  if (delay_done && !busy_r) state_nx = S_RV;
      S_RV:    if (wr_cnt == rounds_cfg - ONE_R) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    global_stage      = state;
    link.input_ready  = !reset && ((state == S_IDLE) ? !frame_active
                                   : (state == S_PARAM || state == S_PREP));
    link.output_valid = frame_active && (hdr_phase || out_round < wr_cnt);
    corr_pad          = '0;
    corr_pad[CORR_W-1:0] = corr_buf[out_round];
    case (hdr_idx)
      3'd0:    link.output_data = hdr_iter;
      3'd1:    link.output_data = {6'b0, hdr_status};
      3'd2:    link.output_data = hdr_cycles[31:24];
      3'd3:    link.output_data = hdr_cycles[23:16];
      3'd4:    link.output_data = hdr_cycles[15:8];
      3'd5:    link.output_data = hdr_cycles[7:0];
      default: link.output_data = corr_pad[{out_byte, 3'b000} +: 8];
    endcase
  end

  // The header must include the increment of the final PEELING cycle, hence the *_nx values.
  always_comb begin
    cycle_nx  = cycle_counter;
    status_nx = status;
    if (state == S_LOAD) begin
      cycle_nx  = 32'd1;
      status_nx = 2'b00;
    end else if (state == S_GROW || settle) begin
      if (cycle_counter != '1) cycle_nx = cycle_counter + 32'd1;
      if (cycle_nx == '1)      status_nx[1] = 1'b1;
      if (timeout_take)        status_nx[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;  odd_r <= 1'b0;
      measurements <= '0;  rounds_cfg <= ROUNDS_MAX;  rounds_loaded <= '0;
      byte_cnt <= '0;  delay_cnt <= '0;  iteration_counter <= '0;
      cycle_counter <= '0;  status <= '0;
      hdr_iter <= '0;  hdr_status <= '0;  hdr_cycles <= '0;
      corr_buf <= '0;  wr_cnt <= '0;  frame_active <= 1'b0;
      hdr_idx <= '0;  out_round <= '0;  out_byte <= '0;
    end else begin
      busy_r        <= |busy_PE;
      odd_r         <= |odd_clusters_PE;
      cycle_counter <= cycle_nx;
      status        <= status_nx;
      if (state_nx != state)          delay_cnt <= '0;
      else if (settle && !delay_done) delay_cnt <= delay_cnt + 1'b1;

      if (out_fire) begin
        if (hdr_phase) hdr_idx <= hdr_idx + 1'b1;
        else if (out_byte == OB_LAST) begin
          out_byte  <= '0;
          out_round <= out_round + 1'b1;
          if (out_round == rounds_cfg - ONE_R) frame_active <= 1'b0;
        end else out_byte <= out_byte + 1'b1;
      end

      case (state)
        S_IDLE:  if (in_fire && link.input_data == MEASUREMENT_DATA_HEADER) begin
                   rounds_loaded <= '0;
                   byte_cnt      <= '0;
                 end
        S_PARAM: if (in_fire)
                   rounds_cfg <= (link.input_data == 8'd0 || link.input_data > U_BYTE)
                                 ? ROUNDS_MAX : link.input_data[RND_W-1:0];
        S_PREP:  if (in_fire) begin
                   measurements <= meas_shift;
                   if (byte_cnt == BYTE_LAST) begin
                     byte_cnt      <= '0;
                     rounds_loaded <= rounds_loaded + 1'b1;
                   end else byte_cnt <= byte_cnt + 1'b1;
                 end
        S_LOAD:  iteration_counter <= '0;
        S_MERGE: if (state_nx == S_GROW) iteration_counter <= iteration_counter + 1'b1;
        S_PEEL:  if (state_nx == S_RV) begin
                   hdr_iter     <= 8'(iteration_counter);
                   hdr_status   <= status_nx;
                   hdr_cycles   <= cycle_nx;
                   frame_active <= 1'b1;
                   hdr_idx      <= '0;
                   out_round    <= '0;
                   out_byte     <= '0;
                   wr_cnt       <= '0;
                 end
        S_RV:    begin
                   corr_buf[wr_cnt] <= correction;
                   wr_cnt           <= wr_cnt + 1'b1;
                 end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_configurable_decode_controller.sv
// Bench for configurable_decode_controller: table of decode scenarios checked through a
// byte scoreboard, plus hand sequences for output backpressure and reset mid-operation.
module tb_configurable_decode_controller;
  localparam logic [2:0] S_IDLE = 3'd0, S_PREP = 3'd2, S_LOAD = 3'd3,
                         S_GROW = 3'd4, S_MERGE = 3'd5, S_RV = 3'd7;
  localparam logic [7:0] MSG_START = 8'h01, MSG_HDR = 8'h02;

  typedef struct {
    logic       cfg_en;
    logic [7:0] cfg;
    logic       junk;
    int         grows;
    int         rounds;
    logic [7:0] iter;
    logic [7:0] st;
    logic [31:0] cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] busy_PE, odd_clusters_PE;
  logic [7:0]  measurements;
  logic [10:0] correction;
  logic [2:0]  global_stage;

  configurable_decode_controller_if lnk();

  configurable_decode_controller #(
    .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(3),
    .ITERATION_COUNTER_WIDTH(8), .MAX_ITERATIONS(3), .MAXIMUM_DELAY(2)
  ) dut (
    .clk(clk), .reset(reset), .link(lnk),
    .busy_PE(busy_PE), .odd_clusters_PE(odd_clusters_PE),
    .measurements(measurements), .correction(correction), .global_stage(global_stage)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int xfer_cnt = 0, grow_cnt = 0, odd_grows = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] corr_vals[3];
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: a byte moves at the posedge following a negedge with valid && ready.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset && lnk.output_valid && lnk.output_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_byte actual=%0h required=none", lnk.output_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", lnk.output_data, e);
        end
      end
    end
  end

  // PE-array model: presents the correction for round k during the k-th RESULT_VALID cycle.
  initial begin
    int k = 0;
    correction = '0;
    forever begin
      @(negedge clk);
      if (global_stage == S_RV && k < 3) begin
        correction = corr_vals[k];
        k++;
      end else if (global_stage != S_RV) k = 0;
    end
  end

  // Odd clusters persist until the requested number of GROW entries has been seen.
  initial begin
    forever begin
      @(negedge clk);
      if (global_stage == S_GROW) begin
        grow_cnt++;
        if (grow_cnt >= odd_grows) odd_clusters_PE = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    lnk.input_data  = b;
    lnk.input_valid = 1'b1;
    @(negedge clk);
    while (!lnk.input_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!lnk.input_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_ready required=ready byte=%0h", b);
    end
    @(posedge clk); #1;
    lnk.input_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] iter, input logic [7:0] st,
                            input logic [31:0] cyc, input int rounds);
    logic [15:0] c;
    exp_q.push_back(iter);
    exp_q.push_back(st);
    exp_q.push_back(cyc[31:24]);
    exp_q.push_back(cyc[23:16]);
    exp_q.push_back(cyc[15:8]);
    exp_q.push_back(cyc[7:0]);
    for (int r = 0; r < rounds; r++) begin
      c = 16'(corr_vals[r]);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL frame_incomplete actual=%0d_left required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
    check("valid_after_frame", lnk.output_valid, 0);
    check("idle_ready_back", lnk.input_ready, 1);
  endtask

  task automatic set_corr(input int seed);
    for (int r = 0; r < 3; r++) corr_vals[r] = 11'(seed * 317 + r * 679 + 1445);
  endtask

  task automatic load_rounds(input int rounds);
    logic [7:0] b;
    send_byte(MSG_HDR);
    check("hdr_to_prep", global_stage, S_PREP);
    for (int r = 0; r < rounds; r++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      check("meas_stage", global_stage, S_LOAD);
      check("meas_value", measurements, b);
    end
  endtask

  task automatic run_decode(input vec_t v, input int seed);
    odd_grows = v.grows;
    grow_cnt  = 0;
    odd_clusters_PE = (v.grows > 0) ? '1 : '0;
    set_corr(seed);
    if (v.cfg_en) begin
      send_byte(MSG_START);
      send_byte(v.cfg);
      check("cfg_to_idle", global_stage, S_IDLE);
    end
    if (v.junk) begin
      send_byte(8'h55);
      check("junk_dropped", global_stage, S_IDLE);
    end
    load_rounds(v.rounds);
    push_frame(v.iter, v.st, v.cyc, v.rounds);
    wait_frame();
    check("grow_entries", 32'(grow_cnt), 32'(v.iter));
  endtask

  initial begin
    int n, base, bad_data, bad_rdy;
    logic [7:0] held;
    vec_t v;
    // cycles = 1 (load) + 3 per MERGE visit + 1 per GROW + 3 for PEELING
    tbl[0] = '{1'b1, 8'h02, 1'b0, 0,  2, 8'd0, 8'h00, 32'd7};
    tbl[1] = '{1'b1, 8'h00, 1'b1, 2,  3, 8'd2, 8'h00, 32'd15};
    tbl[2] = '{1'b1, 8'h09, 1'b0, 99, 3, 8'd3, 8'h01, 32'd19};
    tbl[3] = '{1'b1, 8'h03, 1'b0, 1,  3, 8'd1, 8'h00, 32'd11};
    tbl[4] = '{1'b1, 8'h01, 1'b0, 0,  1, 8'd0, 8'h00, 32'd7};

    reset = 1'b1;
    busy_PE = '0; odd_clusters_PE = '0;
    lnk.input_data = '0; lnk.input_valid = 1'b0; lnk.output_ready = 1'b1;
    set_corr(0);
    @(negedge clk);
    check("rst_stage", global_stage, S_IDLE);
    check("rst_valid", lnk.output_valid, 0);
    check("rst_in_ready", lnk.input_ready, 0);
    check("rst_meas", measurements, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", lnk.input_ready, 1);

    for (int i = 0; i < 5; i++) run_decode(tbl[i], i + 1);

    // Backpressure mid-correction: byte held, host HEADER refused until the frame drains.
    odd_clusters_PE = '0;
    set_corr(9);
    send_byte(MSG_START);
    send_byte(8'h02);
    base = xfer_cnt;
    load_rounds(2);
    push_frame(8'd0, 8'h00, 32'd7, 2);
    n = 0;
    while (xfer_cnt < base + 7 && n < 200) begin @(posedge clk); #1; n++; end
    check("bp_reach", 32'(xfer_cnt - base), 32'd7);
    lnk.output_ready = 1'b0;
    lnk.input_data = MSG_HDR; lnk.input_valid = 1'b1;
    @(negedge clk);
    held = lnk.output_data;
    check("hold_valid", lnk.output_valid, 1);
    bad_data = 0; bad_rdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (lnk.output_data !== held || lnk.output_valid !== 1'b1) bad_data++;
      if (lnk.input_ready !== 1'b0) bad_rdy++;
    end
    check("hold_stable", 32'(bad_data), 0);
    check("hdr_blocked", 32'(bad_rdy), 0);
    @(posedge clk); #1;
    lnk.input_valid = 1'b0;
    lnk.output_ready = 1'b1;
    wait_frame();

    // Reset while merging with odd clusters stuck.
    odd_grows = 99; grow_cnt = 0; odd_clusters_PE = '1;
    load_rounds(2);
    n = 0;
    while (global_stage != S_MERGE && n < 50) begin @(negedge clk); n++; end
    check("reach_merge", global_stage, S_MERGE);
    reset = 1'b1;
    #1;
    check("rst_merge_stage", global_stage, S_IDLE);
    check("rst_merge_valid", lnk.output_valid, 0);
    check("rst_merge_ready", lnk.input_ready, 0);
    odd_clusters_PE = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", lnk.input_ready, 1);

    // Reset partway through the output frame.
    odd_grows = 0; grow_cnt = 0;
    set_corr(11);
    base = xfer_cnt;
    load_rounds(3);
    push_frame(8'd0, 8'h00, 32'd7, 3);
    n = 0;
    while (xfer_cnt < base + 3 && n < 200) begin @(posedge clk); #1; n++; end
    check("midframe_reach", 32'(xfer_cnt - base), 32'd3);
    reset = 1'b1;
    #1;
    check("rst_frame_valid", lnk.output_valid, 0);
    check("rst_frame_stage", global_stage, S_IDLE);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean decode afterwards relies on the reset value of three rounds.
    v = '{1'b0, 8'h00, 1'b0, 0, 3, 8'd0, 8'h00, 32'd7};
    run_decode(v, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
